uop_crack_queue: RTL

- Parametrised front half of the decode stage that replaces the single-entry instruction replay buffer and the fixed atomic step counters.
- Buffers fetched instructions in a BUF_DEPTH-entry FIFO so a pipelined instruction memory can keep streaming during stalls.
- Expands each head instruction into 1..MAX_STEPS micro-op slots: fetch_add = 3, swap = 2, everything else = 1.
- Presents one micro-op per cycle to the decode field logic over a valid/ready handshake.

---
 rtl/decode_pkg.sv | 22 ++
 rtl/instr_fifo.sv | 53 +++++
 rtl/uop_crack_queue.sv | 94 +++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// Opcode constants and micro-op step counts shared by the decode front end.
package decode_pkg;

    localparam logic [4:0] OP_FADD_ABS = 5'd16;
    localparam logic [4:0] OP_FADD_REL = 5'd17;
    localparam logic [4:0] OP_FADD_IMM = 5'd18;
    localparam logic [4:0] OP_SWAP_ABS = 5'd19;
    localparam logic [4:0] OP_SWAP_REL = 5'd20;
    localparam logic [4:0] OP_SWAP_IMM = 5'd21;

    localparam logic [3:0] FADD_STEPS = 4'd3;
    localparam logic [3:0] SWAP_STEPS = 4'd2;

    function automatic logic [3:0] nsteps_of(input logic [4:0] opcode);
        case (opcode)
            OP_FADD_ABS, OP_FADD_REL, OP_FADD_IMM: return FADD_STEPS;
            OP_SWAP_ABS, OP_SWAP_REL, OP_SWAP_IMM: return SWAP_STEPS;
            default:                               return 4'd1;
        endcase
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Circular instruction buffer; full/empty come from the occupancy count.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; entries are only read once count covers them.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uop_crack_queue.sv
// Buffers fetched instructions and cracks each head instruction into 1..MAX_STEPS micro-ops.
module uop_crack_queue
    import decode_pkg::*;
#(
    parameter int BUF_DEPTH  = 4,
    parameter int MAX_STEPS  = 4,
    parameter bit ATOMICS_EN = 1'b1,
    localparam int STEP_W = $clog2(MAX_STEPS),
    localparam int CW     = $clog2(BUF_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              halt,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [31:0]       in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_pc,
    output logic [STEP_W-1:0] out_step,
    output logic              out_last,
    output logic              out_is_atomic,
    output logic              out_is_fetch_add,
    output logic              crack_busy,
    output logic [CW-1:0]     count
);

    if ((BUF_DEPTH < 2) || ((BUF_DEPTH & (BUF_DEPTH - 1)) != 0) || (MAX_STEPS < 3)) begin : g_bad_param
        $error("uop_crack_queue: BUF_DEPTH must be a power of two >= 2 and MAX_STEPS >= 3");
    end

    logic [63:0]       head;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              fire;
    logic [4:0]        opcode;
    logic [3:0]        nsteps;
    logic [STEP_W-1:0] last_step;
    logic [STEP_W-1:0] step;

    assign in_ready  = !full && !halt && !flush;
    assign out_valid = !empty && !halt && !flush;
    assign push      = in_valid && in_ready;
    assign fire      = out_valid && out_ready;
    assign pop       = fire && out_last;

    instr_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata ({in_instr, in_pc}),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign out_instr = head[63:32];
    assign out_pc    = head[31:0];
    assign opcode    = out_instr[31:27];
    assign out_step  = step;

    assign nsteps    = ATOMICS_EN ? nsteps_of(opcode) : 4'd1;
    assign last_step = STEP_W'(nsteps - 4'd1);

    // Decoded flags are masked when empty so a stale slot never looks live.
    assign out_last         = !empty && (step == last_step);
    assign out_is_atomic    = !empty && ATOMICS_EN && (opcode >= OP_FADD_ABS) && (opcode <= OP_SWAP_IMM);
    assign out_is_fetch_add = !empty && ATOMICS_EN && (opcode >= OP_FADD_ABS) && (opcode <= OP_FADD_IMM);
    assign crack_busy       = out_is_atomic && (step != '0);

    // A stalled micro-op simply holds its step and is replayed from the head entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step <= '0;
        end else if (flush) begin
            step <= '0;
        end else if (fire) begin
            if (out_last) step <= '0;
            else          step <= step + STEP_W'(1);
        end
    end

endmodule
